// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the single-port data memory.
// Port 0 is the CPU MEM stage, port 1 the debug/loader master; one access per 3 cycles.
module dmem_arbiter #(
    parameter int DW   = 64,
    parameter int SIZE = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [DW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic          err0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [DW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic          err1,
    output logic [DW-1:0] rdata1,
    output logic          MemRead,
    output logic          MemWrite,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [DW-1:0] ADDR_LIMIT = DW'(8 * SIZE);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          last_grant;
    logic          grant_id;
    logic          cmd_id;
    logic          cmd_we;
    logic [DW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [DW-1:0] resp_data;
    logic          cmd_bad;

    assign cmd_bad = (cmd_addr[2:0] != 3'b000) || (cmd_addr >= ADDR_LIMIT);

    // On a tie the port that was not granted last wins.
    always_comb begin
        grant_id = 1'b0;
        if (req0 && req1) begin
            grant_id = ~last_grant;
        end else if (req1) begin
            grant_id = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cmd_id     <= 1'b0;
            cmd_we     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            resp_data  <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && (req0 || req1)) begin
                cmd_id     <= grant_id;
                last_grant <= grant_id;
                cmd_we     <= grant_id ? we1    : we0;
                cmd_addr   <= grant_id ? addr1  : addr0;
                cmd_wdata  <= grant_id ? wdata1 : wdata0;
            end
            if (state == ACCESS) begin
                resp_data <= (!cmd_bad && !cmd_we) ? mem_rdata : '0;
            end
        end
    end

    // Memory pins and acknowledges decode registered state only; no path from req.
    always_comb begin
        state_next = state;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        ack0       = 1'b0;
        ack1       = 1'b0;
        err0       = 1'b0;
        err1       = 1'b0;
        rdata0     = '0;
        rdata1     = '0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                state_next = RESP;
                if (!cmd_bad) begin
                    MemRead  = ~cmd_we;
                    MemWrite = cmd_we;
                    mem_addr = cmd_addr;
                    if (cmd_we) begin
                        mem_wdata = cmd_wdata;
                    end
                end
            end
            RESP: begin
                state_next = IDLE;
                if (cmd_id) begin
                    ack1   = 1'b1;
                    err1   = cmd_bad;
                    rdata1 = resp_data;
                end else begin
                    ack0   = 1'b1;
                    err0   = cmd_bad;
                    rdata0 = resp_data;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1024-word data memory.
module tb_dmem_arbiter;

    localparam int DW   = 64;
    localparam int SIZE = 1024;

    localparam logic [63:0] VAL_A = 64'h1111_2222_3333_4444;
    localparam logic [63:0] VAL_B = 64'h5555_6666_7777_8888;
    localparam logic [63:0] VAL_C = 64'h9999_AAAA_BBBB_CCCC;
    localparam logic [63:0] VAL_D = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] VAL_P = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] VAL_Q = 64'hCAFE_F00D_CAFE_F00D;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, we0, req1, we1;
    logic [DW-1:0] addr0, wdata0, addr1, wdata1;
    logic          ack0, err0, ack1, err1;
    logic [DW-1:0] rdata0, rdata1;
    logic          MemRead, MemWrite;
    logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;

    int passes = 0;
    int fails  = 0;

    dmem_arbiter #(.DW(DW), .SIZE(SIZE)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0), .err0(err0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .err1(err1), .rdata1(rdata1),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [0:SIZE-1];
    always @(posedge clk) if (MemWrite) mem[mem_addr[12:3]] <= mem_wdata;
    assign mem_rdata = MemRead ? mem[mem_addr[12:3]] : '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Single-port transaction starting in IDLE (just after an edge); ends back in IDLE.
    task automatic do_access(input bit port, input bit we, input logic [63:0] addr,
                             input logic [63:0] wdata, input logic [63:0] rdata_exp,
                             input bit err_exp);
        bit valid;
        valid = !err_exp;
        if (port == 1'b0) begin
            req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
        end
        @(posedge clk); #1;
        chk("acc_memwrite", MemWrite, valid && we);
        chk("acc_memread", MemRead, valid && !we);
        chk("acc_memaddr", mem_addr, valid ? addr : 64'd0);
        if (valid && we) chk("acc_wdata", mem_wdata, wdata);
        chk("acc_noack", {ack0, ack1}, 2'b00);
        @(posedge clk); #1;
        chk("resp_ack0", ack0, port == 1'b0);
        chk("resp_ack1", ack1, port == 1'b1);
        chk("resp_err", port ? err1 : err0, err_exp);
        chk("resp_rdata", port ? rdata1 : rdata0, rdata_exp);
        chk("resp_memwrite", MemWrite, 1'b0);
        if (port == 1'b0) req0 = 1'b0; else req1 = 1'b0;
        @(posedge clk); #1;
        chk("idle_quiet", {ack0, ack1, err0, err1, MemRead, MemWrite}, 6'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        #2;
        chk("rst_flags", {ack0, ack1, err0, err1, MemRead, MemWrite}, 6'd0);
        chk("rst_memaddr", mem_addr, 64'd0);
        chk("rst_memwdata", mem_wdata, 64'd0);
        chk("rst_rdata", rdata0 | rdata1, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Write then read back 0x10 from port 0, and preload a few words.
        do_access(1'b0, 1'b1, 64'h10, VAL_D, 64'd0, 1'b0);
        do_access(1'b0, 1'b0, 64'h10, 64'd0, VAL_D, 1'b0);
        do_access(1'b0, 1'b1, 64'h00, VAL_A, 64'd0, 1'b0);
        do_access(1'b0, 1'b1, 64'h08, VAL_B, 64'd0, 1'b0);
        do_access(1'b0, 1'b1, 64'h18, VAL_C, 64'd0, 1'b0);
        do_access(1'b0, 1'b1, 64'h20, VAL_P, 64'd0, 1'b0);

        // Misaligned read, out-of-range write, then word 0 must be intact.
        do_access(1'b1, 1'b0, 64'h13, 64'd0, 64'd0, 1'b1);
        do_access(1'b0, 1'b1, 64'h2000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
        do_access(1'b0, 1'b0, 64'h00, 64'd0, VAL_A, 1'b0);

        // Fresh reset, then both ports request continuously: grants 0,1,0,1.
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 64'h00;
        req1 = 1'b1; we1 = 1'b0; addr1 = 64'h08;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            chk($sformatf("cont_ack0_%0d", k), ack0, (k == 2 || k == 8));
            chk($sformatf("cont_ack1_%0d", k), ack1, (k == 5 || k == 11));
            if (ack0) chk($sformatf("cont_rdata0_%0d", k), rdata0, VAL_A);
            if (ack1) chk($sformatf("cont_rdata1_%0d", k), rdata1, VAL_B);
        end
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;

        // Port 1 holds req across four reads; acks spaced 3 cycles apart.
        req1 = 1'b1; we1 = 1'b0; addr1 = 64'h00;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("b2b_memaddr_%0d", i), mem_addr, 64'(i * 8));
            chk($sformatf("b2b_noack_%0d", i), ack1, 1'b0);
            @(posedge clk); #1;
            chk($sformatf("b2b_ack1_%0d", i), ack1, 1'b1);
            case (i)
                0: chk("b2b_rdata_0", rdata1, VAL_A);
                1: chk("b2b_rdata_1", rdata1, VAL_B);
                2: chk("b2b_rdata_2", rdata1, VAL_D);
                default: chk("b2b_rdata_3", rdata1, VAL_C);
            endcase
            if (i == 3) req1 = 1'b0; else addr1 = 64'((i + 1) * 8);
            @(posedge clk); #1;
            chk($sformatf("b2b_gap_%0d", i), ack1, 1'b0);
        end

        // Reset during the ACCESS cycle of a write aborts it.
        req0 = 1'b1; we0 = 1'b1; addr0 = 64'h20; wdata0 = VAL_Q;
        @(posedge clk); #1;
        chk("abort_memwrite_on", MemWrite, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_memwrite_off", MemWrite, 1'b0);
        chk("abort_memaddr", mem_addr, 64'd0);
        chk("abort_memwdata", mem_wdata, 64'd0);
        req0 = 1'b0;
        @(posedge clk); #1;
        chk("abort_noack_rst", {ack0, ack1}, 2'b00);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_noack_after", {ack0, ack1, MemRead, MemWrite}, 4'd0);

        // First tie after reset goes to port 0; aborted write left 0x20 intact.
        req0 = 1'b1; we0 = 1'b0; addr0 = 64'h20;
        req1 = 1'b1; we1 = 1'b0; addr1 = 64'h18;
        @(posedge clk); #1;
        chk("tie_memaddr0", mem_addr, 64'h20);
        chk("tie_memread0", MemRead, 1'b1);
        @(posedge clk); #1;
        chk("tie_acks0", {ack0, ack1}, 2'b10);
        chk("tie_rdata0", rdata0, VAL_P);
        req0 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("tie_memaddr1", mem_addr, 64'h18);
        @(posedge clk); #1;
        chk("tie_acks1", {ack0, ack1}, 2'b01);
        chk("tie_rdata1", rdata1, VAL_C);
        req1 = 1'b0;
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", passes, passes + fails);
        $finish;
    end

endmodule
